// File: rtl/apb_gpio_irq_ctrl.sv
// APB GPIO block: direction/output registers, synchronised + debounced inputs,
// and per-pad edge/level interrupt detection with W1C status.
module apb_gpio_irq_ctrl #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned PAD_NUM        = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEB_W          = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [PAD_NUM-1:0]        gpio_i,
  output logic [PAD_NUM-1:0]        gpio_o,
  output logic [PAD_NUM-1:0]        gpio_oe_o,
  output logic [PAD_NUM-1:0]        gpio_in_sync_o,
  output logic                      interrupt_o
);

  localparam int unsigned TW = 2 * PAD_NUM;

  localparam logic [3:0] A_DIR   = 4'd0;
  localparam logic [3:0] A_OUT   = 4'd1;
  localparam logic [3:0] A_IN    = 4'd2;
  localparam logic [3:0] A_SET   = 4'd3;
  localparam logic [3:0] A_CLR   = 4'd4;
  localparam logic [3:0] A_EN    = 4'd5;
  localparam logic [3:0] A_TYPE0 = 4'd6;
  localparam logic [3:0] A_TYPE1 = 4'd7;
  localparam logic [3:0] A_STAT  = 4'd8;
  localparam logic [3:0] A_THR   = 4'd9;

  logic [PAD_NUM-1:0] dir_q, dir_d, out_q, out_d, irq_en_q, irq_en_d;
  logic [PAD_NUM-1:0] irq_status_q, irq_status_d;
  logic [PAD_NUM-1:0] filt_q, filt_d, filt_prev_q;
  logic [TW-1:0]      irq_type_q, irq_type_d;
  logic [DEB_W-1:0]   deb_thr_q, deb_thr_d;
  logic [PAD_NUM-1:0] sync_q [SYNC_STAGES];
  logic [DEB_W-1:0]   cnt_q [PAD_NUM];
  logic [DEB_W-1:0]   cnt_d [PAD_NUM];

  logic [3:0]         idx_c;
  logic               err_c, wr_c, thr_wr_c;
  logic [PAD_NUM-1:0] wdata_c, w1c_c, event_c, synced_c;
  logic [63:0]        type_full_c, type_wr_c;
  logic [31:0]        rdata_c;
  logic               unused_c;

  assign idx_c       = PADDR[5:2];
  assign wdata_c     = PWDATA[PAD_NUM-1:0];
  assign synced_c    = sync_q[SYNC_STAGES-1];
  assign type_full_c = 64'(irq_type_q);
  assign unused_c    = ^{PADDR, PWDATA};

  // Unmapped offsets and writes to the read-only IN register are rejected.
  assign err_c = PSEL & PENABLE & ((idx_c > A_THR) | (PWRITE & (idx_c == A_IN)));
  assign wr_c  = PSEL & PENABLE & PWRITE & ~err_c;

  assign PREADY      = 1'b1;
  assign PSLVERR     = err_c;
  assign PRDATA      = rdata_c;
  assign gpio_o      = out_q;
  assign gpio_oe_o   = dir_q;
  assign gpio_in_sync_o = filt_q;
  assign interrupt_o = |irq_status_q;

  always_comb begin
    rdata_c = '0;
    if (PSEL) begin
      case (idx_c)
        A_DIR:   rdata_c = 32'(dir_q);
        A_OUT:   rdata_c = 32'(out_q);
        A_IN:    rdata_c = 32'(filt_q);
        A_EN:    rdata_c = 32'(irq_en_q);
        A_TYPE0: rdata_c = type_full_c[31:0];
        A_TYPE1: rdata_c = type_full_c[63:32];
        A_STAT:  rdata_c = 32'(irq_status_q);
        A_THR:   rdata_c = 32'(deb_thr_q);
        default: rdata_c = '0;
      endcase
    end
  end

  always_comb begin
    dir_d     = dir_q;
    out_d     = out_q;
    irq_en_d  = irq_en_q;
    deb_thr_d = deb_thr_q;
    type_wr_c = type_full_c;
    w1c_c     = '0;
    thr_wr_c  = 1'b0;
    if (wr_c) begin
      case (idx_c)
        A_DIR:   dir_d = wdata_c;
        A_OUT:   out_d = wdata_c;
        A_SET:   out_d = out_q | wdata_c;
        A_CLR:   out_d = out_q & ~wdata_c;
        A_EN:    irq_en_d = wdata_c;
        A_TYPE0: type_wr_c[31:0] = PWDATA;
        A_TYPE1: type_wr_c[63:32] = PWDATA;
        A_STAT:  w1c_c = wdata_c;
        A_THR: begin
          deb_thr_d = PWDATA[DEB_W-1:0];
          thr_wr_c  = 1'b1;
        end
        default: ;
      endcase
    end
    irq_type_d = TW'(type_wr_c);
  end

  // Event detection on the filtered input; a new event beats a same-cycle W1C.
  always_comb begin
    event_c = '0;
    for (int p = 0; p < PAD_NUM; p++) begin
      case (irq_type_q[2*p +: 2])
        2'b00:   event_c[p] = filt_q[p] & ~filt_prev_q[p];
        2'b01:   event_c[p] = ~filt_q[p] & filt_prev_q[p];
        2'b10:   event_c[p] = filt_q[p] ^ filt_prev_q[p];
        default: event_c[p] = filt_q[p];
      endcase
    end
    irq_status_d = (irq_status_q & ~w1c_c) | (irq_en_q & event_c);
  end

  // Debounce: accept the synced value once it has disagreed for DEB_THR+1 cycles.
  always_comb begin
    filt_d = filt_q;
    for (int p = 0; p < PAD_NUM; p++) begin
      cnt_d[p] = '0;
      if (!thr_wr_c && (synced_c[p] != filt_q[p])) begin
        if (cnt_q[p] == deb_thr_q) begin
          filt_d[p] = synced_c[p];
        end else begin
          cnt_d[p] = cnt_q[p] + DEB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dir_q        <= '0;
      out_q        <= '0;
      irq_en_q     <= '0;
      irq_type_q   <= '0;
      irq_status_q <= '0;
      deb_thr_q    <= '0;
      filt_q       <= '0;
      filt_prev_q  <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int p = 0; p < PAD_NUM; p++) cnt_q[p] <= '0;
    end else begin
      dir_q        <= dir_d;
      out_q        <= out_d;
      irq_en_q     <= irq_en_d;
      irq_type_q   <= irq_type_d;
      irq_status_q <= irq_status_d;
      deb_thr_q    <= deb_thr_d;
      filt_q       <= filt_d;
      filt_prev_q  <= filt_q;
      sync_q[0]    <= gpio_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int p = 0; p < PAD_NUM; p++) cnt_q[p] <= cnt_d[p];
    end
  end

endmodule
